// File: rtl/uart_pkg.sv
// uart_pkg -- definitions shared by the UART receiver and transmitter.
//   uart_state_t      : 2-bit frame state encoding (IDLE/START/DATA/STOP)
//   BAUD_DIV_DEFAULT  : clk cycles per bit at 100 MHz / 9600 baud
//   HALF_DIV_DEFAULT  : clk cycles from start-bit edge to start-bit centre
//   BAUD_CNT_W        : width of the bit-period counter
//   BIT_CNT_W         : width of the data-bit index
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int BAUD_DIV_DEFAULT = 10417;
    localparam int HALF_DIV_DEFAULT = 5208;
    localparam int BAUD_CNT_W       = 15;
    localparam int BIT_CNT_W        = 3;

    // High-to-low transition between two consecutive samples of the line.
    function automatic logic is_fall(input logic prev, input logic cur);
        return prev & ~cur;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// uart_sync -- two-flop synchronizer for the asynchronous serial line.
//   clk    in  : system clock
//   rst    in  : asynchronous active-low reset; both flops load 1 (line idle)
//   din    in  : asynchronous serial input
//   din_s  out : din retimed into the clk domain (two clk of latency)
module uart_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic din_s
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta  <= 1'b1;
            din_s <= 1'b1;
        end else begin
            meta  <= din;
            din_s <= meta;
        end
    end

endmodule

// File: rtl/uart_recv.sv
// uart_recv -- UART 8N1 receiver.
//   Samples the synchronized line at bit centres, assembles 8 data bits
//   LSB first and checks the stop bit.
//   clk        in  : system clock
//   rst        in  : asynchronous active-low reset
//   din        in  : serial line, idle high, asynchronous to clk
//   valid      out : one-cycle pulse, data holds a newly received good byte
//   data       out : last good byte, stable until the next valid pulse
//   frame_err  out : one-cycle pulse, stop bit sampled low, byte discarded
module uart_recv
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT,
    parameter int HALF_DIV = HALF_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic       valid,
    output logic [7:0] data,
    output logic       frame_err
);

    localparam logic [BAUD_CNT_W-1:0] BAUD_LAST = BAUD_CNT_W'(BAUD_DIV - 1);
    localparam logic [BAUD_CNT_W-1:0] HALF_LAST = BAUD_CNT_W'(HALF_DIV - 1);

    uart_state_t             state;
    uart_state_t             state_nxt;
    logic [BAUD_CNT_W-1:0]   baud_cnt;
    logic [BIT_CNT_W-1:0]    bit_cnt;
    logic [7:0]              shreg;
    logic                    din_s;
    logic                    din_s_d;
    logic                    fall;
    logic                    half_tick;
    logic                    baud_tick;

    // Line synchronizer and edge detector
    uart_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (din),
        .din_s (din_s)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) din_s_d <= 1'b1;
        else      din_s_d <= din_s;
    end

    assign fall      = is_fall(din_s_d, din_s);
    assign half_tick = (baud_cnt == HALF_LAST);
    assign baud_tick = (baud_cnt == BAUD_LAST);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fall) state_nxt = START;
            // A start bit that is high again at its centre was only a glitch.
            START:   if (half_tick) state_nxt = din_s ? IDLE : DATA;
            DATA:    if (baud_tick && (bit_cnt == 3'd7)) state_nxt = STOP;
            // Leaving at the stop-bit centre leaves half a bit to catch a
            // start bit that follows with no idle gap.
            STOP:    if (baud_tick) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Counters, shift register and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            // Counter restarts on every state change and wraps once per bit
            // in DATA, so every sample point is a fresh count from zero.
            if ((state_nxt != state) || (state == IDLE) || baud_tick)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + 1'b1;

            if (state == START)
                bit_cnt <= '0;
            else if ((state == DATA) && baud_tick)
                bit_cnt <= bit_cnt + 1'b1;

            // Shifting in at the MSB leaves the first (LSB) bit at bit 0.
            if ((state == DATA) && baud_tick)
                shreg <= {din_s, shreg[7:1]};

            valid     <= (state == STOP) && baud_tick && din_s;
            frame_err <= (state == STOP) && baud_tick && !din_s;

            if ((state == STOP) && baud_tick && din_s)
                data <= shreg;
        end
    end

endmodule

// File: tb/tb_uart_recv.sv
module tb_uart_recv;

    localparam int BIT_CLK = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       din = 1'b1;
    logic       valid;
    logic [7:0] data;
    logic       frame_err;

    int checks = 0;
    int errors = 0;

    int          cyc = 0;
    int          vcnt = 0;
    int          fcnt = 0;
    int          vcyc_prev = 0;
    int          vcyc_last = 0;
    logic [7:0]  vdata_prev = 8'h00;
    logic [7:0]  vdata_last = 8'h00;
    int          overlap_seen = 0;

    uart_recv #(.BAUD_DIV(16), .HALF_DIV(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .valid     (valid),
        .data      (data),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            vcnt       <= vcnt + 1;
            vcyc_prev  <= vcyc_last;
            vcyc_last  <= cyc;
            vdata_prev <= vdata_last;
            vdata_last <= data;
        end
        if (frame_err) fcnt <= fcnt + 1;
        if (valid && frame_err) overlap_seen <= 1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        din = b;
        repeat (BIT_CLK) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        din = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    typedef struct {
        logic [7:0] byte_v;
        logic       stop;
        int         exp_v;
        int         exp_f;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int v0, f0;

        vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
        vecs[1] = '{8'h5A, 1'b0, 0, 1, 8'hA5};
        vecs[2] = '{8'h3C, 1'b1, 1, 0, 8'h3C};
        vecs[3] = '{8'h01, 1'b1, 1, 0, 8'h01};
        vecs[4] = '{8'h80, 1'b0, 0, 1, 8'h01};

        // Reset state
        rst = 1'b0;
        din = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", valid, 0);
        check("rst_data", data, 0);
        check("rst_frame_err", frame_err, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        idle(20);

        // Single frames, good and bad stop bits
        foreach (vecs[k]) begin
            v0 = vcnt; f0 = fcnt;
            send_frame(vecs[k].byte_v, vecs[k].stop);
            idle(40);
            check($sformatf("vec%0d_valid_cnt", k), vcnt - v0, vecs[k].exp_v);
            check($sformatf("vec%0d_ferr_cnt", k), fcnt - f0, vecs[k].exp_f);
            check($sformatf("vec%0d_data", k), data, vecs[k].exp_data);
        end

        // Back-to-back frames, no idle gap
        v0 = vcnt; f0 = fcnt;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(40);
        check("b2b_valid_cnt", vcnt - v0, 2);
        check("b2b_first_data", vdata_prev, 8'h00);
        check("b2b_second_data", vdata_last, 8'hFF);
        check("b2b_spacing", vcyc_last - vcyc_prev, 160);
        check("b2b_ferr_cnt", fcnt - f0, 0);

        // Short low glitch, then a good frame
        v0 = vcnt; f0 = fcnt;
        din = 1'b0;
        repeat (4) @(posedge clk); #1;
        idle(40);
        check("glitch_valid_cnt", vcnt - v0, 0);
        check("glitch_ferr_cnt", fcnt - f0, 0);
        send_frame(8'h3C, 1'b1);
        idle(40);
        check("after_glitch_valid_cnt", vcnt - v0, 1);
        check("after_glitch_data", data, 8'h3C);

        // Reset in the middle of a frame
        v0 = vcnt; f0 = fcnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        rst = 1'b0;
        din = 1'b1;
        @(negedge clk);
        check("midrst_valid", valid, 0);
        check("midrst_data", data, 0);
        check("midrst_frame_err", frame_err, 0);
        repeat (5) @(posedge clk); #1;
        rst = 1'b1;
        idle(200);
        check("midrst_partial_valid", vcnt - v0, 0);
        check("midrst_partial_ferr", fcnt - f0, 0);
        send_frame(8'h81, 1'b1);
        idle(40);
        check("midrst_next_valid_cnt", vcnt - v0, 1);
        check("midrst_next_data", data, 8'h81);

        // Break: line held low
        v0 = vcnt; f0 = fcnt;
        din = 1'b0;
        repeat (300) @(posedge clk); #1;
        check("break_ferr_cnt", fcnt - f0, 1);
        check("break_valid_cnt", vcnt - v0, 0);
        idle(60);
        check("break_release_ferr_cnt", fcnt - f0, 1);
        send_frame(8'h96, 1'b1);
        idle(40);
        check("after_break_valid_cnt", vcnt - v0, 1);
        check("after_break_data", data, 8'h96);

        check("valid_ferr_overlap", overlap_seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
